// File: rtl/axi_mem_arbiter.sv
// Burst-granular round-robin arbiter for the AXI slave's single-port memory array; grants register one cycle after req.
// Optional idle-grant watchdog is compiled in when ARB_WATCHDOG_EN is defined.
module axi_mem_arbiter #(
  parameter int LEN_WIDTH   = 8,
  parameter int WDOG_CYCLES = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESTN,
  input  logic                 wr_req,
  input  logic [LEN_WIDTH-1:0] wr_len,
  input  logic                 wr_beat,
  output logic                 wr_gnt,
  input  logic                 rd_req,
  input  logic [LEN_WIDTH-1:0] rd_len,
  input  logic                 rd_beat,
  output logic                 rd_gnt,
  output logic                 mem_sel,
  output logic                 busy,
  output logic                 wdog_err
);

  typedef enum logic [1:0] {IDLE, GNT_WR, GNT_RD} state_t;

  state_t               state;
  logic                 last_rd;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 own_beat;
  logic                 final_beat;
  logic                 wdog_trip;
  logic                 release_now;
  logic                 take_wr;
  logic                 take_rd;

  // Beats from the engine that does not own the array never reach the counter.
  assign own_beat    = ((state == GNT_WR) && wr_beat) || ((state == GNT_RD) && rd_beat);
  assign final_beat  = own_beat && (beat_cnt == len_q);
  assign release_now = final_beat || wdog_trip;

`ifdef ARB_WATCHDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);
  logic [7:0] idle_cnt;

  assign wdog_trip = (state != IDLE) && !own_beat && (idle_cnt == WDOG_LAST);

  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) begin
      idle_cnt <= '0;
    end else if ((state == IDLE) || own_beat || wdog_trip) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

  // Next owner: from IDLE a tie goes to whoever was not served last; on release only the other engine may follow directly.
  always_comb begin
    take_wr = 1'b0;
    take_rd = 1'b0;
    case (state)
      IDLE: begin
        take_wr = wr_req && (!rd_req || last_rd);
        take_rd = rd_req && !take_wr;
      end
      GNT_WR:  take_rd = release_now && rd_req;
      GNT_RD:  take_wr = release_now && wr_req;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESTN) begin
    if (!ARESTN) begin
      state    <= IDLE;
      last_rd  <= 1'b1;
      len_q    <= '0;
      beat_cnt <= '0;
      wr_gnt   <= 1'b0;
      rd_gnt   <= 1'b0;
      mem_sel  <= 1'b0;
      busy     <= 1'b0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_trip;
      if (release_now) begin
        last_rd <= (state == GNT_RD);
      end
      if (take_wr || take_rd) begin
        state    <= take_wr ? GNT_WR : GNT_RD;
        len_q    <= take_wr ? wr_len : rd_len;
        beat_cnt <= '0;
        wr_gnt   <= take_wr;
        rd_gnt   <= take_rd;
        mem_sel  <= take_rd;
        busy     <= 1'b1;
      end else if (release_now) begin
        // mem_sel deliberately keeps its last value while idle.
        state  <= IDLE;
        wr_gnt <= 1'b0;
        rd_gnt <= 1'b0;
        busy   <= 1'b0;
      end else if (own_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter: stimulus queues expected output changes, a monitor checks them.
module tb_axi_mem_arbiter;

  logic       ACLK;
  logic       ARESTN;
  logic       wr_req;
  logic [7:0] wr_len;
  logic       wr_beat;
  logic       wr_gnt;
  logic       rd_req;
  logic [7:0] rd_len;
  logic       rd_beat;
  logic       rd_gnt;
  logic       mem_sel;
  logic       busy;
  logic       wdog_err;

  axi_mem_arbiter #(.LEN_WIDTH(8), .WDOG_CYCLES(16)) dut (
    .ACLK     (ACLK),
    .ARESTN   (ARESTN),
    .wr_req   (wr_req),
    .wr_len   (wr_len),
    .wr_beat  (wr_beat),
    .wr_gnt   (wr_gnt),
    .rd_req   (rd_req),
    .rd_len   (rd_len),
    .rd_beat  (rd_beat),
    .rd_gnt   (rd_gnt),
    .mem_sel  (mem_sel),
    .busy     (busy),
    .wdog_err (wdog_err)
  );

  // Output tuple {wr_gnt, rd_gnt, mem_sel, busy, wdog_err}
  localparam logic [4:0] T_WR      = 5'b10010;
  localparam logic [4:0] T_RD      = 5'b01110;
  localparam logic [4:0] T_IDLE_W  = 5'b00000;
  localparam logic [4:0] T_IDLE_R  = 5'b00100;
  localparam logic [4:0] T_RD_WDOG = 5'b01111;

  typedef struct {
    logic [4:0] val;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [4:0] mon_prev;
  logic [4:0] mon_cur;
  int         cyc;
  int         checks;
  int         errors;
  int         t0;
  logic       wr_beat_en;
  logic       rd_beat_en;
  logic       rd_force;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge ACLK);
    wr_beat = wr_beat_en & wr_gnt;
    rd_beat = (rd_beat_en & rd_gnt) | rd_force;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_ev(input logic [4:0] v, input int c);
    ev_t e;
    e.val = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change of the output tuple must match the next queued expectation, at its cycle.
  always @(negedge ACLK) begin
    if (!ARESTN) begin
      mon_prev = '0;
    end else begin
      mon_cur = {wr_gnt, rd_gnt, mem_sel, busy, wdog_err};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_ev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event: expected %b at cycle %0d, not seen (cycle %0d, outputs %b)",
                 mon_ev.val, mon_ev.cyc, cyc, mon_cur);
      end
      if (mon_cur !== mon_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: outputs %b at cycle %0d, none expected", mon_cur, cyc);
        end else begin
          mon_ev = exp_q.pop_front();
          if (mon_cur !== mon_ev.val || cyc != mon_ev.cyc) begin
            errors++;
            $display("FAIL event: got %b at cycle %0d, expected %b at cycle %0d",
                     mon_cur, cyc, mon_ev.val, mon_ev.cyc);
          end
        end
        mon_prev = mon_cur;
      end
      checks++;
      if (wr_gnt && rd_gnt) begin
        errors++;
        $display("FAIL gnt_exclusive: wr_gnt=1 rd_gnt=1 at cycle %0d, expected at most one", cyc);
      end
      checks++;
      if (busy !== (wr_gnt | rd_gnt)) begin
        errors++;
        $display("FAIL busy: got %b, expected %b at cycle %0d", busy, wr_gnt | rd_gnt, cyc);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_prev = '0;
    ARESTN = 1'b0;
    wr_req = 1'b0; wr_len = '0; wr_beat = 1'b0;
    rd_req = 1'b0; rd_len = '0; rd_beat = 1'b0;
    wr_beat_en = 1'b0; rd_beat_en = 1'b0; rd_force = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_outputs", {wr_gnt, rd_gnt, mem_sel, busy, wdog_err}, 5'b00000);
    ARESTN = 1'b1;
    tick();

    // Tie straight after reset: WR first, RD handed off, WR again
    t0 = cyc;
    wr_req = 1'b1; rd_req = 1'b1; wr_len = 8'd1; rd_len = 8'd1;
    wr_beat_en = 1'b1; rd_beat_en = 1'b1;
    expect_ev(T_WR, t0 + 1);
    expect_ev(T_RD, t0 + 3);
    expect_ev(T_WR, t0 + 5);
    expect_ev(T_IDLE_W, t0 + 7);
    wait_until(t0 + 3);
    rd_req = 1'b0;
    wait_until(t0 + 5);
    wr_req = 1'b0;
    wait_until(t0 + 10);

    // Single write, len 3: four cycles of grant
    t0 = cyc;
    wr_req = 1'b1; wr_len = 8'd3;
    expect_ev(T_WR, t0 + 1);
    expect_ev(T_IDLE_W, t0 + 5);
    wait_until(t0 + 1);
    wr_req = 1'b0;
    wait_until(t0 + 8);

    // Foreign rd_beat pulses during a WR grant must not count
    t0 = cyc;
    wr_req = 1'b1; wr_len = 8'd2; wr_beat_en = 1'b0; rd_force = 1'b1;
    expect_ev(T_WR, t0 + 1);
    expect_ev(T_IDLE_W, t0 + 9);
    wait_until(t0 + 1);
    wr_req = 1'b0;
    wait_until(t0 + 5);
    rd_force = 1'b0;
    wr_beat_en = 1'b1;
    wait_until(t0 + 12);

    // Max-length read: 256 beats, then mem_sel holds 1 in IDLE
    t0 = cyc;
    rd_req = 1'b1; rd_len = 8'd255; rd_beat_en = 1'b1;
    expect_ev(T_RD, t0 + 1);
    expect_ev(T_IDLE_R, t0 + 257);
    wait_until(t0 + 1);
    rd_req = 1'b0;
    wait_until(t0 + 256);
    check("maxlen_still_granted", {wr_gnt, rd_gnt, mem_sel, busy, wdog_err}, T_RD);
    wait_until(t0 + 260);

    // Single-beat write, len 0
    t0 = cyc;
    wr_req = 1'b1; wr_len = 8'd0;
    expect_ev(T_WR, t0 + 1);
    expect_ev(T_IDLE_W, t0 + 2);
    wait_until(t0 + 1);
    wr_req = 1'b0;
    wait_until(t0 + 5);

    // Stalled write owner (len 4, two beats) with a read pending
    t0 = cyc;
    wr_req = 1'b1; wr_len = 8'd4; wr_beat_en = 1'b1;
    expect_ev(T_WR, t0 + 1);
    wait_until(t0 + 1);
    wr_req = 1'b0; rd_req = 1'b1; rd_len = 8'd1; rd_beat_en = 1'b1;
    wait_until(t0 + 2);
    wr_beat_en = 1'b0;
`ifdef ARB_WATCHDOG_EN
    expect_ev(T_RD_WDOG, t0 + 19);
    expect_ev(T_RD, t0 + 20);
    expect_ev(T_IDLE_R, t0 + 21);
    wait_until(t0 + 18);
    check("wdog_before_trip", {wr_gnt, rd_gnt, mem_sel, busy, wdog_err}, T_WR);
    wait_until(t0 + 19);
    rd_req = 1'b0;
    wait_until(t0 + 40);
    wr_beat_en = 1'b1;
    wait_until(t0 + 48);
`else
    expect_ev(T_RD, t0 + 44);
    expect_ev(T_IDLE_R, t0 + 46);
    wait_until(t0 + 40);
    check("stall_holds_grant", {wr_gnt, rd_gnt, mem_sel, busy, wdog_err}, T_WR);
    wr_beat_en = 1'b1;
    wait_until(t0 + 44);
    rd_req = 1'b0;
    wait_until(t0 + 48);
`endif

    // Reset in the middle of an 8-beat read after 3 beats
    t0 = cyc;
    rd_req = 1'b1; rd_len = 8'd7; rd_beat_en = 1'b1; wr_beat_en = 1'b0;
    expect_ev(T_RD, t0 + 1);
    wait_until(t0 + 1);
    rd_req = 1'b0;
    wait_until(t0 + 3);
    rd_beat_en = 1'b0;
    wait_until(t0 + 4);
    #2 ARESTN = 1'b0;
    #1 check("async_reset_outputs", {wr_gnt, rd_gnt, mem_sel, busy, wdog_err}, 5'b00000);
    tick();
    tick();
    ARESTN = 1'b1;
    t0 = cyc;
    rd_req = 1'b1; rd_len = 8'd7; rd_beat_en = 1'b1;
    expect_ev(T_RD, t0 + 1);
    expect_ev(T_IDLE_R, t0 + 9);
    wait_until(t0 + 1);
    rd_req = 1'b0;
    wait_until(t0 + 8);
    check("restart_needs_8_beats", {wr_gnt, rd_gnt, mem_sel, busy, wdog_err}, T_RD);
    wait_until(t0 + 14);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events left unmatched, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
